// File: rtl/serial_eq_comparator.sv
// Bit-serial equality comparator: operands shift out LSB-first through a single xnor_gate
// cell, and the block reports equal/not-equal plus the lowest mismatching bit index.

module xnor_gate (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = ~(a ^ b);
endmodule

module serial_eq_comparator #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned EARLY_EXIT = 1,
    parameter int unsigned IDX_W      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             eq,
    output logic [IDX_W-1:0] mismatch_idx,
    output logic             busy
);
    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [IDX_W:0] CntLast = (IDX_W+1)'(WIDTH - 1);
    localparam logic [IDX_W:0] CntOne  = (IDX_W+1)'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, b_sh_q;
    logic             match_q;
    logic [IDX_W:0]   cnt_q;
    logic             eq_q;
    logic [IDX_W-1:0] idx_q;
    logic             xnor_out;
    logic             accept;
    logic             last_bit;
    logic             early_stop;

    xnor_gate u_xnor (
        .a (a_sh_q[0]),
        .b (b_sh_q[0]),
        .y (xnor_out)
    );

    assign accept     = (state_q == StIdle) && in_valid;
    assign last_bit   = (cnt_q == CntLast);
    assign early_stop = (EARLY_EXIT != 0) && !xnor_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (in_valid) state_d = StRun;
            StRun:   if (early_stop || last_bit) state_d = StDone;
            StDone:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        busy      = (state_q == StRun);
        out_valid = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            idx_q   <= '0;
        end else if (accept) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            match_q <= 1'b1;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            idx_q   <= '0;
        end else if (state_q == StRun) begin
            match_q <= match_q & xnor_out;
            a_sh_q  <= a_sh_q >> 1;
            b_sh_q  <= b_sh_q >> 1;
            cnt_q   <= cnt_q + CntOne;
            // Only the first mismatch is latched, so the lowest index wins.
            if (!xnor_out && match_q) begin
                idx_q <= cnt_q[IDX_W-1:0];
            end
            if (early_stop || last_bit) begin
                eq_q <= match_q & xnor_out;
            end
        end
    end

    assign eq           = eq_q;
    assign mismatch_idx = idx_q;

endmodule

// File: tb/tb_serial_eq_comparator.sv
// Self-checking bench: two comparators (EARLY_EXIT=0 and 1) share stimulus and are checked
// every cycle against a transaction-level model, plus directed literal expectations.

module tb_serial_eq_comparator;
    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_ready     [2];
    logic       out_valid    [2];
    logic       eq           [2];
    logic [2:0] mismatch_idx [2];
    logic       busy         [2];

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Model: phase 0 idle, 1 run, 2 done; m_left counts remaining run cycles.
    int m_phase [2] = '{0, 0};
    int m_left  [2] = '{0, 0};
    bit m_eq    [2] = '{0, 0};
    int m_idx   [2] = '{0, 0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        serial_eq_comparator #(
            .WIDTH      (8),
            .EARLY_EXIT (g)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .in_valid     (in_valid),
            .in_ready     (in_ready[g]),
            .a            (a),
            .b            (b),
            .out_valid    (out_valid[g]),
            .out_ready    (out_ready),
            .eq           (eq[g]),
            .mismatch_idx (mismatch_idx[g]),
            .busy         (busy[g])
        );
    end

    function automatic int low_idx(input logic [7:0] x, input logic [7:0] y);
        for (int i = 0; i < 8; i++) begin
            if (x[i] != y[i]) return i;
        end
        return 0;
    endfunction

    function automatic int exp_lat(input logic [7:0] x, input logic [7:0] y, input int ee);
        if (x == y) return 8;
        return (ee != 0) ? low_idx(x, y) + 1 : 8;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (reset) begin
                m_phase[g] <= 0;
            end else begin
                case (m_phase[g])
                    0: if (in_valid) begin
                        m_phase[g] <= 1;
                        m_left[g]  <= exp_lat(a, b, g);
                        m_eq[g]    <= (a == b);
                        m_idx[g]   <= low_idx(a, b);
                    end
                    1: begin
                        if (m_left[g] == 1) m_phase[g] <= 2;
                        m_left[g] <= m_left[g] - 1;
                    end
                    default: if (out_ready) m_phase[g] <= 0;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int g = 0; g < 2; g++) begin
                check($sformatf("in_ready[%0d]", g), 64'(in_ready[g]), 64'(m_phase[g] == 0));
                check($sformatf("busy[%0d]", g), 64'(busy[g]), 64'(m_phase[g] == 1));
                check($sformatf("out_valid[%0d]", g), 64'(out_valid[g]), 64'(m_phase[g] == 2));
                if (m_phase[g] == 2) begin
                    check($sformatf("eq[%0d]", g), 64'(eq[g]), 64'(m_eq[g]));
                    check($sformatf("mismatch_idx[%0d]", g), 64'(mismatch_idx[g]),
                          64'(m_idx[g]));
                end
            end
        end
    end

    task automatic wait_idle();
        for (int c = 0; c < 60; c++) begin
            if (m_phase[0] == 0 && m_phase[1] == 0) return;
            @(negedge clk);
        end
        check("idle_timeout", 64'(m_phase[0] + m_phase[1]), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        for (int g = 0; g < 2; g++) begin
            check({tag, "_in_ready"}, 64'(in_ready[g]), 64'd1);
            check({tag, "_out_valid"}, 64'(out_valid[g]), 64'd0);
            check({tag, "_busy"}, 64'(busy[g]), 64'd0);
            check({tag, "_eq"}, 64'(eq[g]), 64'd0);
            check({tag, "_idx"}, 64'(mismatch_idx[g]), 64'd0);
        end
    endtask

    // Called at a negedge with both instances idle; out_ready held high.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                          input bit mangle, input int lat0, input int lat1,
                          input bit xeq, input int xidx);
        int lat [2];
        int got_eq [2];
        int got_idx [2];
        int nbusy;
        lat = '{0, 0};
        got_eq = '{0, 0};
        got_idx = '{0, 0};
        nbusy = 0;
        a = ta;
        b = tb_v;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        if (mangle) a = 8'h00;
        for (int c = 0; c <= 20; c++) begin
            for (int g = 0; g < 2; g++) begin
                if (out_valid[g] && lat[g] == 0) begin
                    lat[g]     = c;
                    got_eq[g]  = int'(eq[g]);
                    got_idx[g] = int'(mismatch_idx[g]);
                end
            end
            if (busy[1]) nbusy++;
            @(negedge clk);
        end
        check({tag, "_lat_ee0"}, 64'(lat[0]), 64'(lat0));
        check({tag, "_lat_ee1"}, 64'(lat[1]), 64'(lat1));
        check({tag, "_busy_ee1"}, 64'(nbusy), 64'(lat1));
        for (int g = 0; g < 2; g++) begin
            check({tag, "_eq"}, 64'(got_eq[g]), 64'(xeq));
            check({tag, "_idx"}, 64'(got_idx[g]), 64'(xidx));
        end
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 8'h00;
        b = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        run_op("equal_a5", 8'hA5, 8'hA5, 1'b0, 8, 8, 1'b1, 0);
        run_op("bit2_a5a1", 8'hA5, 8'hA1, 1'b0, 8, 3, 1'b0, 2);
        run_op("multi_81", 8'h81, 8'h00, 1'b0, 8, 1, 1'b0, 0);

        // Backpressure: result must hold while out_ready is low and new operands are refused.
        out_ready = 1'b0;
        a = 8'hFF;
        b = 8'h7F;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid[0] && out_valid[1]) break;
            @(negedge clk);
        end
        check("bp_valid_seen", 64'(out_valid[0] & out_valid[1]), 64'd1);
        a = 8'h12;
        b = 8'h34;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                check("bp_hold_valid", 64'(out_valid[g]), 64'd1);
                check("bp_hold_eq", 64'(eq[g]), 64'd0);
                check("bp_hold_idx", 64'(mismatch_idx[g]), 64'd7);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            check("bp_release_ready", 64'(in_ready[g]), 64'd1);
            check("bp_release_busy", 64'(busy[g]), 64'd0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int g = 0; g < 2; g++) check("bp_next_accept", 64'(busy[g]), 64'd1);
        wait_idle();

        // Reset in the middle of a run discards the operation.
        a = 8'h00;
        b = 8'h00;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_run");
        reset = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) check("rst_run_no_valid", 64'(out_valid[g]), 64'd0);
        run_op("after_rst_3c", 8'h3C, 8'h3C, 1'b0, 8, 8, 1'b1, 0);

        run_op("late_change_55", 8'h55, 8'h55, 1'b1, 8, 8, 1'b1, 0);

        // Randomized traffic with occasional resets and backpressure.
        for (int i = 0; i < 600; i++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 9) < 7);
            reset = ($urandom_range(0, 99) < 2);
            a = 8'($urandom);
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = a ^ (8'h01 << $urandom_range(0, 7));
                default: b = 8'($urandom);
            endcase
            @(negedge clk);
        end
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_eq_comparator.md
Name: serial_eq_comparator

Overview:
- Bit-serial equality comparator; the sequential stage directly downstream of the single-bit xnor_gate cell.
- Accepts two WIDTH-bit operands through a valid/ready handshake. Shifts them out LSB-first, one bit per clock, into one instantiated xnor_gate, and ANDs the per-bit results into a running match flag.
- Reports equal/not-equal and the index of the first mismatching bit; used where an area-cheap, multi-cycle compare is acceptable.

Parameters:
- WIDTH, 8, operand width in bits; legal range 2..64.
- EARLY_EXIT, 1, 1 = finish on the first mismatching bit; 0 = always scan all WIDTH bits.
- IDX_W, $clog2(WIDTH), width of mismatch_idx (derived; do not override).

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes result.
- eq  output  1  1 = a equal to b.
- mismatch_idx  output  IDX_W  bit index of the lowest mismatching bit; 0 when eq=1.
- busy  output  1  high in RUN state.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, eq=0, mismatch_idx=0, busy=0, internal shift registers and count=0.
- Reset is sampled only at a clock edge. A reset asserted in any state aborts the operation on that edge and discards the result, with no out_valid pulse.
- Compare datapath:
  - a_sh[0] and b_sh[0] feed one xnor_gate instance.
  - match is the registered AND of all xnor outputs so far.
  - cnt is an IDX_W+1-bit count of bits processed.
- FSM:
  - IDLE: in_ready=1. On in_valid&&in_ready, load a_sh=a, b_sh=b, match=1, cnt=0, then go to RUN. No other action.
  - RUN: in_ready=0, busy=1. Each cycle: match <= match & xnor_out; shift a_sh and b_sh right by 1; cnt <= cnt+1.
    - If xnor_out=0 and match=1 (first mismatch), latch mismatch_idx=cnt[IDX_W-1:0].
    - EARLY_EXIT=1 and xnor_out=0: go to DONE with eq=0.
    - Otherwise, when cnt==WIDTH-1: go to DONE with eq = match & xnor_out.
  - DONE: out_valid=1; eq and mismatch_idx held stable. On out_ready=1, go to IDLE and drop out_valid on that edge. out_valid never drops without out_ready.
- Latency, from the accept edge E to out_valid high:
  - Equal operands: exactly WIDTH cycles, in both modes.
  - EARLY_EXIT=1 with first mismatch at bit k: k+1 cycles.
  - EARLY_EXIT=0: always WIDTH cycles.
- Throughput: one operation at a time. in_ready is low in RUN and DONE. The DONE→IDLE edge does not accept a new operand; the next accept is earliest one cycle later.
- in_valid is ignored outside IDLE. a and b are sampled only on the accept edge; later changes have no effect.
- With EARLY_EXIT=0 and multiple mismatches, mismatch_idx reports the lowest index.
- out_ready held high continuously: out_valid is a one-cycle pulse.
- No X propagation: eq and mismatch_idx are driven from registers only.

Test Plan:
- WIDTH=8, EARLY_EXIT=1: a=0xA5, b=0xA5, out_ready=1 -> out_valid 8 cycles after accept, eq=1, mismatch_idx=0, busy high 8 cycles.
- WIDTH=8, EARLY_EXIT=1: a=0xA5, b=0xA1 (bit 2 differs) -> out_valid 3 cycles after accept, eq=0, mismatch_idx=2.
- WIDTH=8, EARLY_EXIT=0: a=0x81, b=0x00 -> out_valid 8 cycles after accept, eq=0, mismatch_idx=0.
- Backpressure: a=0xFF, b=0x7F (bit 7 differs), out_ready=0 for 5 cycles after out_valid -> out_valid, eq=0, mismatch_idx=7 held stable; in_valid with new operands during the hold is not accepted; out_ready=1 -> IDLE, new operands accepted one cycle later.
- Reset in RUN: accept a=0x00, b=0x00, assert reset at cycle 3 -> next edge all outputs at reset values, in_ready=1, no out_valid; a subsequent compare of 0x3C vs 0x3C gives eq=1.
- Input change after accept: accept a=0x55, b=0x55, then drive a=0x00 during RUN -> eq=1.
